// File: rtl/mean_unpooling.sv
// Mean-unpooling expander: takes one pooled fixed-point scalar and streams it out
// as a size-element vector of scalar/size (or plain broadcast), also collected into om.
module mean_unpooling #(
    parameter int IL     = 4,
    parameter int FL     = 16,
    parameter int size   = 4,
    parameter int width  = $clog2(size),
    parameter int DIVIDE = 1,
    localparam int W     = IL + FL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [width-1:0]          out_idx,
    output logic [size-1:0][W-1:0]    om,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [width-1:0] LAST = width'(size - 1);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     q;
    logic [width-1:0] pointer;
    logic [W-1:0]     im_div;

    // Arithmetic shift divides by the power-of-two size, rounding toward -inf.
    assign im_div = W'($signed(im) >>> width);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid && in_ready) state_next = EMIT;
            EMIT:    if (out_valid && out_ready && (pointer == LAST)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = en && rst_n;
            EMIT:    out_valid = en;
            default: ;
        endcase
    end

    // NOTE: om is a register bank (not RAM) and must read back as zero after reset, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            pointer <= '0;
            om      <= '0;
            done    <= 1'b0;
        end else if (en) begin
            done <= (state_next == DONE);
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q       <= (DIVIDE != 0) ? im_div : im;
                        pointer <= '0;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        om[pointer] <= q;
                        if (pointer != LAST) pointer <= pointer + width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = q;
    assign out_idx  = pointer;

endmodule

// File: tb/tb_mean_unpooling.sv
// Self-checking bench for mean_unpooling: directed vector table, multi-cycle corner
// sequences, and a randomized run scored against a transaction-level model.
module tb_mean_unpooling;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int SIZE = 4;
    localparam int WD   = $clog2(SIZE);
    localparam int W    = IL + FL;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic in_valid;
    logic [W-1:0] im;
    logic out_ready;

    logic                   in_ready,  in_ready_b;
    logic                   out_valid, out_valid_b;
    logic [W-1:0]           out_data,  out_data_b;
    logic [WD-1:0]          out_idx,   out_idx_b;
    logic [SIZE-1:0][W-1:0] om,        om_b;
    logic                   done,      done_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mean_unpooling #(.IL(IL), .FL(FL), .size(SIZE), .DIVIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .im(im), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .om(om), .done(done)
    );

    mean_unpooling #(.IL(IL), .FL(FL), .size(SIZE), .DIVIDE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready_b),
        .im(im), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_idx(out_idx_b), .om(om_b), .done(done_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: floor of the signed scalar divided by the vector length.
    function automatic logic [W-1:0] mean_of(input logic [W-1:0] x);
        int v;
        int r;
        v = $signed(x);
        r = v / SIZE;
        if ((v % SIZE) != 0 && v < 0) r = r - 1;
        return W'(r);
    endfunction

    typedef struct {
        logic [W-1:0] im;
        logic [W-1:0] exp_mean;
    } vec_t;

    vec_t vecs[6];

    // Full pass with out_ready held high; starts and ends just after a rising edge, state IDLE.
    task automatic run_vec(input logic [W-1:0] x, input logic [W-1:0] exp_m);
        im = x; in_valid = 1'b1; out_ready = 1'b1; en = 1'b1;
        @(negedge clk);
        check("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; im = '0;
        for (int k = 0; k < SIZE; k++) begin
            @(negedge clk);
            check("vec_out_valid", out_valid, 1);
            check("vec_out_idx", out_idx, k);
            check("vec_out_data", out_data, exp_m);
            check("vec_bcast_data", out_data_b, x);
            check("vec_no_done", done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("vec_done", done, 1);
        check("vec_done_ov", out_valid, 0);
        check("vec_done_ir", in_ready, 0);
        check("vec_om", om, {SIZE{exp_m}});
        check("vec_om_b", om_b, {SIZE{x}});
        @(posedge clk); #1;
        @(negedge clk);
        check("vec_ready_again", in_ready, 1);
        check("vec_done_clear", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    // Randomized-run model state.
    bit busy;
    int emitted;
    logic [W-1:0] cur_m, cur_b;
    logic [W-1:0] exp_om [SIZE];
    logic [W-1:0] exp_om_b [SIZE];
    logic [SIZE-1:0][W-1:0] pk, pk_b;

    initial begin
        vecs[0] = '{im: 20'h40000, exp_mean: 20'h10000};
        vecs[1] = '{im: 20'hF0000, exp_mean: 20'hFC000};
        vecs[2] = '{im: 20'hFFFFD, exp_mean: 20'hFFFFF};
        vecs[3] = '{im: 20'h00003, exp_mean: 20'h00000};
        vecs[4] = '{im: 20'h80000, exp_mean: 20'hE0000};
        vecs[5] = '{im: 20'h7FFFF, exp_mean: 20'h1FFFF};

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; im = '0; out_ready = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_om", om, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i].im, vecs[i].exp_mean);

        // Backpressure for 3 cycles at idx 1, then en low for 2 cycles at idx 2.
        begin
            bit   orq [10] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
            bit   enq [10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
            bit   ovq [10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0};
            int   idq [10] = '{0, 1, 1, 1, 1, 2, 2, 2, 3, 0};
            im = 20'h40000; in_valid = 1'b1; out_ready = 1'b1; en = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                out_ready = orq[c]; en = enq[c];
                @(negedge clk);
                check("bp_out_valid", out_valid, ovq[c]);
                check("bp_done", done, (c == 9));
                if (c < 9) begin
                    check("bp_out_idx", out_idx, idq[c]);
                    check("bp_out_data", out_data, 20'h10000);
                end else begin
                    check("bp_om", om, {SIZE{20'h10000}});
                end
                @(posedge clk); #1;
            end
            en = 1'b1;
        end

        // Back-to-back: second scalar held on in_valid through EMIT/DONE.
        im = 20'h12345; in_valid = 1'b1; out_ready = 1'b1; en = 1'b1;
        @(negedge clk);
        check("b2b_first_ready", in_ready, 1);
        @(posedge clk); #1;
        im = 20'h0ABCD;
        for (int c = 1; c <= SIZE + 1; c++) begin
            @(negedge clk);
            check("b2b_busy_ready", in_ready, 0);
            if (c <= SIZE) begin
                check("b2b_idx1", out_idx, c - 1);
                check("b2b_data1", out_data, mean_of(20'h12345));
                check("b2b_bcast1", out_data_b, 20'h12345);
            end else begin
                check("b2b_done1", done_b, 1);
                check("b2b_om_b1", om_b, {SIZE{20'h12345}});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_second_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; im = '0;
        for (int k = 0; k < SIZE; k++) begin
            @(negedge clk);
            check("b2b_idx2", out_idx, k);
            check("b2b_data2", out_data, mean_of(20'h0ABCD));
            check("b2b_bcast2", out_data_b, 20'h0ABCD);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_done2", done, 1);
        check("b2b_om_b2", om_b, {SIZE{20'h0ABCD}});
        @(posedge clk); #1;

        // Reset asserted mid-cycle during EMIT at idx 2.
        im = 20'hC0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("mid_idx", out_idx, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_om", om, 0);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ir", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < SIZE + 2; c++) begin
            @(negedge clk);
            check("mid_no_done", done, 0);
            check("mid_idle_ov", out_valid, 0);
            check("mid_idle_ir", in_ready, 1);
            @(posedge clk); #1;
        end
        run_vec(20'h20000, 20'h08000);

        // Randomized traffic from a fresh reset, scored at transaction level.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 1'b0; emitted = 0; cur_m = '0; cur_b = '0;
        for (int k = 0; k < SIZE; k++) begin exp_om[k] = '0; exp_om_b[k] = '0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = 1'($urandom_range(0, 1));
            im        = W'($urandom);
            @(negedge clk);
            check("rnd_in_ready", in_ready, en && !busy);
            check("rnd_out_valid", out_valid, en && busy && (emitted < SIZE));
            check("rnd_done", done, busy && (emitted == SIZE));
            if (en && busy && emitted < SIZE) begin
                check("rnd_idx", out_idx, emitted);
                check("rnd_data", out_data, cur_m);
                check("rnd_bcast", out_data_b, cur_b);
            end
            if (busy && emitted == SIZE) begin
                for (int k = 0; k < SIZE; k++) begin pk[k] = exp_om[k]; pk_b[k] = exp_om_b[k]; end
                check("rnd_om", om, pk);
                check("rnd_om_b", om_b, pk_b);
            end
            if (en && !busy && in_valid) begin
                busy = 1'b1; emitted = 0; cur_m = mean_of(im); cur_b = im;
            end else if (en && busy && emitted < SIZE && out_ready) begin
                exp_om[emitted] = cur_m; exp_om_b[emitted] = cur_b; emitted++;
            end else if (en && busy && emitted == SIZE) begin
                busy = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mean_unpooling.md
# mean_unpooling

Backward/expansion counterpart of the mean-pooling unit. Accepts one pooled fixed-point scalar over a valid/ready handshake and streams it back out as a `size`-element vector: each element equals the scalar divided by `size`, the mean-pooling gradient. Elements go out one per accepted beat and are also collected into a parallel output vector. It sits on the backward path of the transformer pooling stage and feeds per-token gradient buffers.

## Interface

Parameters:
- `IL`, 4, integer bits of the signed two's-complement fixed-point word.
- `FL`, 16, fractional bits. Word width W = IL+FL.
- `size`, 4, vector length; must be a power of two and ≥2.
- `width`, $clog2(size), index width.
- `DIVIDE`, 1. 1 means each element = input/size; 0 means plain broadcast, each element = input.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable. When 0, all state is frozen and `in_ready`/`out_valid` are forced 0.
- `in_valid`  in  1  pooled scalar present on `im`.
- `in_ready`  out  1  block can accept a scalar.
- `im`  in  W  pooled scalar, signed.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the element.
- `out_data`  out  W  current expanded element.
- `out_idx`  out  width  index of `out_data` within the vector.
- `om`  out  W×size  collected vector, `om[size-1:0]`.
- `done`  out  1  one-cycle pulse: the vector `om` is complete.

## Operation

- FSM states: IDLE, EMIT, DONE.
- Registers: `q` (W bits), `pointer` (width bits), `om`, `done`.
- IDLE
  - `in_ready` = en.
  - On `in_valid && in_ready`: latch `q` = DIVIDE ? (im >>> width) : im, set `pointer` = 0, go to EMIT.
- EMIT
  - `out_valid` = en; `out_data` = q; `out_idx` = pointer.
  - On `out_valid && out_ready`: `om[pointer]` <= q.
    - If `pointer` == size-1: go to DONE.
    - Otherwise `pointer` <= pointer+1.
  - `in_ready` = 0.
- DONE
  - `done` = 1 for exactly this cycle; `in_ready` = 0, `out_valid` = 0; go to IDLE next cycle.
- Arithmetic
  - Division is an arithmetic right shift by `width`, so it rounds toward negative infinity.
  - No saturation is needed, since the result magnitude never exceeds the input.
  - Width is W throughout.
- `om` entries not yet written in the current pass keep their previous values. `om` is fully valid only when `done` is 1, and it holds until overwritten by the next pass.
- `out_data`/`out_idx` are don't-care when `out_valid` is 0. Drive them from `q`/`pointer` regardless.
- `en` low in any state: no transition, no register update, handshakes blocked. On re-enable, resume in the same state with the same `pointer`.

## Timing

- Reset (rst_n low, asynchronous)
  - State IDLE; `q`, `pointer`, every `om` entry = 0; `done` = 0; `in_ready` = 0 while in reset.
  - After reset deasserts, `in_ready` = en.
- Reset mid-EMIT or in DONE: the partial vector is discarded, `om` clears to 0, and no `done` is issued.
- Latency, with the scalar accepted at edge T and `out_ready` held at 1:
  - Element 0 valid in cycle T+1; element k in cycle T+1+k.
  - Last element accepted at edge T+size.
  - `done` is high in cycle T+size+1.
  - `in_ready` is high again in cycle T+size+2.
- Throughput: one vector per size+2 cycles.
- Backpressure: `out_ready` low holds `out_data`/`out_idx` stable and `out_valid` high, with no pointer advance.
- `in_valid` while `in_ready` = 0 is ignored; the scalar is not latched. Upstream must hold it.

## Test plan

- Reset and idle: assert rst_n low mid-cycle, with no clock edge.
  - All `om` = 0, `done` = 0, `out_valid` = 0 immediately.
  - After release with en=1, `in_ready` = 1.
- Basic divide (IL=4, FL=16, size=4): send `im` = 0x40000 (4.0) with `out_ready`=1.
  - `out_data` = 0x10000 with `out_idx` 0,1,2,3 in cycles T+1..T+4.
  - `done` in T+5; all `om` = 0x10000.
- Negative rounding and precision:
  - `im` = 0xF0000 (−1.0) gives elements 0xFC000 (−0.25).
  - `im` = 0xFFFFD gives 0xFFFFF.
  - `im` = 0x00003 gives 0x00000.
- Backpressure and enable: deassert `out_ready` for 3 cycles at idx 1, then drop `en` for 2 cycles at idx 2.
  - `out_idx`/`out_data` stay stable throughout and no element is duplicated or skipped.
  - `done` is delayed by exactly 5 cycles.
- Broadcast (DIVIDE=0) and back-to-back: send `im` = 0x12345, then a second scalar with `in_valid` held high.
  - All elements = 0x12345.
  - The second scalar is accepted exactly at cycle T+size+2.
  - `in_valid` during EMIT/DONE is ignored.
- Reset mid-EMIT at idx 2: `om` is cleared and no `done` is issued. The next scalar produces a clean full vector.
